// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the register-file debug read-out path.
// Holds the dump engine state encoding, the frame header byte and the
// register-file address width.
package cpu_pkg;

  // Dump engine states. ST_CSUM is only reachable when the checksum
  // feature is built in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_READ   = 3'd2,
    ST_SEND   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } dump_state_e;

  // First byte of every dump frame.
  localparam logic [7:0] DUMP_HEADER = 8'hA5;

  // Address width of the 4-entry general-purpose register file.
  localparam int REG_ADDR_W = 2;

endpackage : cpu_pkg

// File: rtl/reg_dump_reader.sv
// Debug read-out engine for the general-purpose register file.
// On dump_req it walks register addresses 0..NUM_REGS-1 through one
// asynchronous read port and emits a valid/ready byte stream:
// header byte, then one byte per register.
// Build option: define REG_DUMP_CHECKSUM_EN to append a running XOR of
// all register bytes (header excluded) as a trailing frame byte.
module reg_dump_reader
  import cpu_pkg::*;
#(
  parameter int                NUM_REGS = 4,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] HEADER   = DATA_W'(DUMP_HEADER)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dump_req,
  output logic [$clog2(NUM_REGS)-1:0] rf_addr,
  input  logic [DATA_W-1:0]           rf_data,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int             ADDR_W   = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e        state_r;
  logic [ADDR_W-1:0]  index_r;
  logic [DATA_W-1:0]  out_data_r;
  logic               out_valid_r;
  logic               busy_r;
  logic               done_r;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]  csum_r;
`endif

  // The read address follows the index register directly, so it is
  // already stable for the whole READ cycle.
  assign rf_addr   = index_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Frame sequencer: single FSM owning all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      index_r     <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_r      <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_r <= '0;
`endif
          if (dump_req) begin
            state_r     <= ST_HEADER;
            out_data_r  <= HEADER;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            index_r     <= '0;
          end else begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end

        ST_HEADER: begin
          // Byte and valid stay put until the consumer takes the header.
          if (out_ready) begin
            state_r     <= ST_READ;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= ST_HEADER;
          end
        end

        ST_READ: begin
          // rf_data is sampled here, so a CPU write landing before this
          // cycle is what gets reported.
          out_data_r  <= rf_data;
          out_valid_r <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_r      <= csum_r ^ rf_data;
`endif
          state_r     <= ST_SEND;
        end

        ST_SEND: begin
          if (out_ready) begin
            if (index_r == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
              // Checksum already folds in the last register (READ preceded).
              state_r     <= ST_CSUM;
              out_data_r  <= csum_r;
              out_valid_r <= 1'b1;
`else
              state_r     <= ST_DONE;
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
`endif
            end else begin
              state_r     <= ST_READ;
              index_r     <= index_r + 1'b1;
              out_valid_r <= 1'b0;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end

`ifdef REG_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (out_ready) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            state_r     <= ST_CSUM;
          end
        end
`endif

        ST_DONE: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          index_r     <= '0;
        end

        default: begin
          // Unreachable encodings fall back to a quiet idle.
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          index_r     <= '0;
        end
      endcase
    end
  end

endmodule : reg_dump_reader

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader. Register file contents live in a
// plain array driving rf_data combinationally; each frame is compared with
// the byte list the frame rules imply (header, registers in address order,
// optional XOR checksum when REG_DUMP_CHECKSUM_EN is defined).
module tb_reg_dump_reader;

  localparam int         NR  = 4;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk;
  logic       rst;
  logic       dump_req;
  logic [1:0] rf_addr;
  logic [7:0] rf_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] regs [NR];

  int err_cnt = 0;
  int chk_cnt = 0;

  reg_dump_reader #(.NUM_REGS(NR), .DATA_W(8), .HEADER(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .dump_req (dump_req),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  assign rf_data = regs[rf_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] s = 8'h00;
    for (int i = 0; i < NR; i++) s = s ^ regs[i];
    return s;
  endfunction

  // Ideal-sink frame with exact cycle positions; edge 0 samples dump_req.
  task automatic run_timed(input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3);
    int         done_cyc;
    logic       ev;
    logic [7:0] ed;
    regs[0] = r0; regs[1] = r1; regs[2] = r2; regs[3] = r3;
    done_cyc = 2 * NR + 2;
`ifdef REG_DUMP_CHECKSUM_EN
    done_cyc = done_cyc + 1;
`endif
    out_ready = 1'b1;
    dump_req  = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      ev = (c == 1) || (c >= 3 && c <= 2 * NR + 1 && (c % 2) == 1);
      if (c == 1) ed = HDR;
      else if (ev) ed = regs[(c - 3) / 2];
      else ed = 8'h00;
`ifdef REG_DUMP_CHECKSUM_EN
      if (c == 2 * NR + 2) begin
        ev = 1'b1;
        ed = xor_all();
      end
`endif
      chk("t_valid", {31'd0, out_valid}, {31'd0, ev});
      if (ev) chk("t_data", {24'd0, out_data}, {24'd0, ed});
      chk("t_busy", {31'd0, busy}, {31'd0, (c <= done_cyc)});
      chk("t_done", {31'd0, done}, {31'd0, (c == done_cyc)});
    end
  endtask

  // Frame with a sink behaviour: 0 random ready, 1 stall R1 three cycles,
  // 2 extra dump_req mid-frame, 3 rewrite R3 after R0 has gone out.
  task automatic run_frame(input int mode);
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         cyc = 0;
    int         stalls = 0;
    int         done_cnt = 0;
    bit         finished = 1'b0;
    bit         wrote = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         n;
    @(posedge clk); #1;
    dump_req  = 1'b1;
    out_ready = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_cnt++;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      dump_req = (mode == 2 && cyc == 4);
      case (mode)
        0: out_ready = ($urandom_range(0, 3) != 0);
        1: begin
          if (out_valid && got.size() == 2 && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (mode == 3 && !wrote && got.size() >= 2) begin
        regs[3] = regs[3] ^ 8'hFF;
        wrote = 1'b1;
      end
    end
    if (!finished) chk("frame_timeout", 32'd0, 32'd1);
    dump_req = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("tail_valid", {31'd0, out_valid}, 32'd0);
      if (done) done_cnt++;
    end
    chk("done_count", done_cnt, 32'd1);
    exp_q.push_back(HDR);
    for (int i = 0; i < NR; i++) exp_q.push_back(regs[i]);
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(xor_all());
`endif
    chk("frame_len", got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("frame_byte", {24'd0, got[i]}, {24'd0, exp_q[i]});
  endtask

  // Start a frame, hold R2 on the bus, then reset asynchronously.
  task automatic run_abort();
    int cyc = 0;
    int n = 0;
    bit hit = 1'b0;
    bit done_seen = 1'b0;
    @(posedge clk); #1;
    dump_req  = 1'b1;
    out_ready = 1'b1;
    while (!hit && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) done_seen = 1'b1;
      if (out_valid && out_ready) n++;
      @(posedge clk); #1;
      dump_req = 1'b0;
      if (out_valid && n == 3) begin
        out_ready = 1'b0;
        hit = 1'b1;
      end
    end
    chk("abort_reached", {31'd0, hit}, 32'd1);
    chk("abort_r2", {24'd0, out_data}, {24'd0, regs[2]});
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr", {30'd0, rf_addr}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("abort_hold_busy", {31'd0, busy}, 32'd0);
    chk("abort_no_done", {31'd0, done_seen}, 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {30'd0, rf_addr}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_timed(8'h11, 8'h22, 8'h33, 8'h44);
    run_timed(8'h01, 8'h02, 8'h04, 8'h08);

    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    run_frame(1);
    run_frame(2);

    for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
    run_abort();
    run_frame(0);

    for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
    run_frame(3);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NR; i++) regs[i] = 8'($urandom);
      run_frame(0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_reg_dump_reader

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Debug read-out engine on the read side of the 4x8-bit general-purpose register file.
- On a request, walks register addresses 0..NUM_REGS-1 through one register-file read port. Emits a framed byte stream on a valid/ready interface: header byte, then one byte per register.
- Sits between the register file and the debug UART/trace path; never writes registers.

Parameters:
- NUM_REGS, 4, registers dumped per request; power of two, minimum 2.
- DATA_W, 8, register and stream byte width.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- dump_req  in  1  start request; sampled only in IDLE.
- rf_addr  out  log2(NUM_REGS)  register-file read address.
- rf_data  in  DATA_W  register-file read data; combinational (asynchronous) with rf_addr.
- out_data  out  DATA_W  stream byte.
- out_valid  out  1  stream byte valid.
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high at a clk edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset: asynchronous clear to IDLE. rf_addr=0, out_data=0, out_valid=0, busy=0, done=0, index=0.
- Reset mid-frame aborts the frame immediately. No done pulse, no partial continuation.
- All outputs are registered. rf_addr is driven from the index register.
- States:
  - IDLE
    - dump_req=1 → HEADER; out_data<=HEADER, out_valid<=1, index<=0.
    - Otherwise stay in IDLE.
  - HEADER
    - Holds out_valid=1 until accepted.
    - On accept → READ; out_valid<=0.
  - READ (exactly one cycle, rf_addr=index)
    - out_data<=rf_data, out_valid<=1.
    - → SEND.
  - SEND
    - Holds out_valid=1 until accepted.
    - On accept with index<NUM_REGS-1 → READ; index<=index+1, out_valid<=0.
    - On accept with index==NUM_REGS-1 → CSUM if CHECKSUM_EN is defined, else DONE.
  - DONE
    - done=1 for this single cycle, out_valid=0.
    - → IDLE; index<=0.
- Stream rules:
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - out_valid never depends combinationally on out_ready.
  - out_valid drops for exactly one cycle (READ) between bytes.
- Latency with out_ready held high and dump_req sampled at edge 0:
  - Without CHECKSUM_EN: header valid in cycle 1; R0 in cycle 3; Rk in cycle 3+2k; done in cycle 2·NUM_REGS+2 (cycle 10 for NUM_REGS=4).
  - With CHECKSUM_EN: checksum in cycle 2·NUM_REGS+2 (cycle 10); done one cycle later (cycle 11).
- Coherency: each register value is the one present during its READ cycle. No whole-file snapshot; the CPU may write during a dump.
- dump_req while busy is ignored and is not queued. dump_req held high re-triggers in the first IDLE cycle after DONE.
- index wraps naturally. The terminal compare stops the frame before any wrap is observable.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- Defined:
  - Running XOR of all register bytes is cleared in IDLE and updated in each READ.
  - CSUM state presents out_data=checksum, out_valid=1 until accepted, then → DONE.
  - The header byte is excluded from the checksum.
- Undefined: no CSUM state, no checksum register. Frame is exactly 1+NUM_REGS bytes.

Decomposition:
- Shared package cpu_pkg:
  - state enum.
  - DUMP_HEADER constant (8'hA5).
  - REG_ADDR_W constant (2).
- No sub-module. Single FSM plus datapath; the checksum accumulator is inline.

Test Plan:
- Regs 11,22,33,44; pulse dump_req; out_ready=1 → bytes A5,11,22,33,44 in cycles 1,3,5,7,9; done=1 in cycle 10; busy high cycles 1–10.
- Same regs; out_ready low for 3 cycles while R1 (22) is valid → 22 held stable, no byte dropped or duplicated; frame completes correctly.
- dump_req pulsed again mid-frame → ignored; exactly one frame and one done pulse.
- rst asserted while R2 is valid → out_valid, busy and rf_addr go 0 asynchronously, no done; next dump_req yields a full fresh frame starting with A5.
- REG_DUMP_CHECKSUM_EN, regs 01,02,04,08 → bytes A5,01,02,04,08,0F; done in cycle 11.
- Register R3 written between the R0 and R3 reads → stream carries the new R3 value.
